keypad_arbiter: RTL

KEYPAD_ARBITER -- requirements
Module: keypad_arbiter

---
 rtl/keypad_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/keypad_arbiter.sv
// Shares one 10-key keypad between three requesters: round-robin grant, edge-detected
// single-key acceptance, inactivity timeout, and a one-cycle dead gap between owners.
//
// state | meaning
// IDLE  | no owner; arbitrate pending requests round-robin
// OWNED | grant held; accepted keys go to the owner, inactivity counted
// GAP   | one dead cycle with grant=0 before arbitrating again
module keypad_arbiter #(
  parameter int TIMEOUT = 600,
  parameter int CNT_W   = 10
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [9:0] keys,
  input  logic [2:0] req,
  input  logic [2:0] rel,
  output logic [2:0] grant,
  output logic [2:0] key_valid,
  output logic [3:0] key_code,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, OWNED, GAP} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [2:0]       grant_q, grant_d;
  logic [2:0]       key_valid_q, key_valid_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [9:0]       keys_q, keys_d;
  logic             acc_q, acc_d;
  logic [3:0]       acc_code_q, acc_code_d;

  logic [9:0] press;
  logic [1:0] pick;
  logic       rel_own, req_own, expired;

  // A press is registered here first, so the owner sees it one cycle after sampling.
  always_comb begin
    keys_d     = keys;
    press      = keys & ~keys_q;
    acc_d      = (press != '0) && ((press & (press - 10'd1)) == '0);
    acc_code_d = '0;
    for (int i = 0; i < 10; i++) begin
      if (press[i]) acc_code_d = 4'(i);
    end
  end

  always_comb begin
    pick = 2'd0;
    case (ptr_q)
      2'd0:    pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    key_valid_d = '0;
    key_code_d  = key_code_q;
    timeout_d   = 1'b0;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    rel_own     = |(rel & grant_q);
    req_own     = |(req & grant_q);
    expired     = !acc_q && (cnt_q == CNT_LAST);
    case (state_q)
      IDLE: begin
        if (req != '0) begin
          state_d = OWNED;
          grant_d = 3'b001 << pick;
          ptr_d   = pick;
          cnt_d   = '0;
        end
      end
      OWNED: begin
        if (acc_q) begin
          key_valid_d = grant_q;
          key_code_d  = acc_code_q;
          cnt_d       = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
        // Dropping req counts as a release, so it also suppresses the timeout pulse.
        if (rel_own || !req_own || expired) begin
          state_d   = GAP;
          grant_d   = '0;
          timeout_d = expired && !rel_own && req_own;
        end
      end
      GAP: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      key_valid_q <= '0;
      key_code_q  <= '0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
      ptr_q       <= 2'd2;
      keys_q      <= keys;
      acc_q       <= 1'b0;
      acc_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      keys_q      <= keys_d;
      acc_q       <= acc_d;
      acc_code_q  <= acc_code_d;
    end
  end

  assign grant     = grant_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign busy      = |grant_q;
  assign timeout   = timeout_q;

endmodule
